// File: rtl/div_pkg.sv
// Shared types and helpers for the odd-ratio divider monitors.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    MEASURE,
    LOCKED
  } div_chk_state_t;

  localparam int TIMEOUT_MULT = 2;

  function automatic int duty_lo(input int n);
    return n / 2;
  endfunction

  function automatic int duty_hi(input int n);
    return n / 2 + 1;
  endfunction

endpackage

// File: rtl/div_edge_sync.sv
// Two-flop sampler of a divided clock with rise/fall detection.
module div_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign lvl  = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/odd_div_checker.sv
// Period/duty/timeout monitor for an odd-ratio divided clock,
// with lock indication and a saturating error counter.
module odd_div_checker
  import div_pkg::*;
#(
  parameter int DIV_N    = 9,
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             clk_div_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             locked,
  output logic             err_period,
  output logic             err_duty,
  output logic             err_timeout,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_count
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [CNT_W-1:0] N_C = CNT_W'(DIV_N);
  localparam logic [CNT_W-1:0] LO_C = CNT_W'(duty_lo(DIV_N));
  localparam logic [CNT_W-1:0] HI_C = CNT_W'(duty_hi(DIV_N));
  localparam logic [CNT_W-1:0] TO_C =
    CNT_W'(TIMEOUT_MULT * DIV_N - 1);
  localparam logic [GW-1:0] LAST_GOOD = GW'(LOCK_CNT - 1);

  div_chk_state_t state;
  div_chk_state_t state_n;

  logic [GW-1:0]    good_run;
  logic [GW-1:0]    good_n;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] hcnt;
  logic             hi_open;
  logic             lvl;
  logic             rise;
  logic             fall;
  logic             cap;
  logic             ep_n;
  logic             ed_n;
  logic             et_n;
  logic             err_ev;

  div_edge_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (clk_div_in),
    .lvl  (lvl),
    .rise (rise),
    .fall (fall)
  );

  always_comb begin
    state_n = state;
    good_n  = good_run;
    cap     = 1'b0;
    ep_n    = 1'b0;
    ed_n    = 1'b0;
    et_n    = 1'b0;
    if (!en) begin
      state_n = IDLE;
      good_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = ACQUIRE;
          good_n  = '0;
        end
        ACQUIRE: begin
          if (rise) begin
            state_n = MEASURE;
            good_n  = '0;
          end
        end
        MEASURE, LOCKED: begin
          if (rise) begin
            cap  = 1'b1;
            ep_n = (cyc != N_C);
            ed_n = (hcnt < LO_C) || (hcnt > HI_C);
            if (ep_n || ed_n) begin
              state_n = MEASURE;
              good_n  = '0;
            end else if (state == MEASURE) begin
              if (good_run == LAST_GOOD) begin
                state_n = LOCKED;
              end
              good_n = good_run + 1'b1;
            end
          end else if (cyc == TO_C) begin
            // Next cycle cyc would hit the limit: report loss once.
            et_n    = 1'b1;
            state_n = ACQUIRE;
            good_n  = '0;
          end
        end
      endcase
    end
  end

  assign err_ev = ep_n | ed_n | et_n;
  assign locked = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      good_run    <= '0;
      cyc         <= '0;
      hcnt        <= '0;
      hi_open     <= 1'b0;
      period_cnt  <= '0;
      high_cnt    <= '0;
      err_period  <= 1'b0;
      err_duty    <= 1'b0;
      err_timeout <= 1'b0;
      err_sticky  <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_n;
      good_run    <= good_n;
      err_period  <= ep_n;
      err_duty    <= ed_n;
      err_timeout <= et_n;
      if (rise) begin
        cyc <= CNT_W'(1);
      end else if (cyc != CNT_MAX) begin
        cyc <= cyc + 1'b1;
      end
      if (rise) begin
        hi_open <= 1'b1;
      end else if (fall) begin
        hi_open <= 1'b0;
      end
      // Only the high phase opened by a seen rising edge counts.
      if (rise) begin
        hcnt <= CNT_W'(1);
      end else if (lvl && hi_open && hcnt != CNT_MAX) begin
        hcnt <= hcnt + 1'b1;
      end
      if (cap) begin
        period_cnt <= cyc;
        high_cnt   <= hcnt;
      end
      if (clr) begin
        err_sticky <= 1'b0;
        err_count  <= '0;
      end else if (err_ev) begin
        err_sticky <= 1'b1;
        if (err_count != ERR_MAX) begin
          err_count <= err_count + 1'b1;
        end
      end
    end
  end

endmodule
